// File: rtl/bsg_axil_fifo_client.sv
// AXI4-Lite subordinate: serialises buffered AW/W/AR into one in-order fifo-style
// request stream and steers the in-order response stream back onto B or R.

module bsg_axil_fifo_client_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] i_data,
  input  logic               i_v,
  output logic               o_ready,
  output logic [width_p-1:0] o_data,
  output logic               o_v,
  input  logic               i_yumi
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w-1:0]   r_wptr, r_rptr;
  logic [cnt_w-1:0]   r_count;
  logic               w_full, w_push, w_pop;
  logic [ptr_w-1:0]   w_wptr_nxt, w_rptr_nxt;

  // Handshake signals are gated by reset so nothing is offered while it is held.
  assign w_full  = (r_count == cnt_w'(els_p));
  assign o_ready = reset_n_i & ~w_full;
  assign o_v     = reset_n_i & (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_v & o_ready;
  assign w_pop   = i_yumi & o_v;

  assign w_wptr_nxt = (r_wptr == ptr_w'(els_p - 1)) ? '0 : r_wptr + ptr_w'(1);
  assign w_rptr_nxt = (r_rptr == ptr_w'(els_p - 1)) ? '0 : r_rptr + ptr_w'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      r_count <= r_count + cnt_w'(w_push) - cnt_w'(w_pop);
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

module bsg_axil_fifo_client #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter int outstanding_els_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,

  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,

  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,

  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,

  output logic [axil_addr_width_p-1:0]   addr_o,
  output logic [axil_data_width_p-1:0]   data_o,
  output logic [axil_data_width_p/8-1:0] wmask_o,
  output logic                           w_o,
  output logic                           v_o,
  input  logic                           ready_and_i,

  input  logic [axil_data_width_p-1:0]   data_i,
  input  logic                           v_i,
  output logic                           ready_and_o
);

  localparam int strb_w = axil_data_width_p / 8;

  logic [axil_addr_width_p-1:0] w_aw_addr, w_ar_addr;
  logic [axil_data_width_p-1:0] w_w_data;
  logic [strb_w-1:0]            w_w_strb;
  logic w_aw_v, w_w_v, w_ar_v;
  logic w_wr_elig, w_rd_elig, w_grant_w, w_req_hs;
  logic w_trk_ready, w_trk_v, w_trk_w, w_rsp_pop;
  logic r_last_grant_w, r_lock_v, r_lock_w;
  logic w_unused;

  assign w_unused = ^{s_axil_awprot_i, s_axil_arprot_i};

  bsg_axil_fifo_client_fifo #(.width_p(axil_addr_width_p), .els_p(2)) aw_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .i_data(s_axil_awaddr_i), .i_v(s_axil_awvalid_i), .o_ready(s_axil_awready_o),
    .o_data(w_aw_addr), .o_v(w_aw_v), .i_yumi(w_req_hs & w_grant_w)
  );

  bsg_axil_fifo_client_fifo #(.width_p(axil_data_width_p + strb_w), .els_p(2)) w_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .i_data({s_axil_wstrb_i, s_axil_wdata_i}), .i_v(s_axil_wvalid_i), .o_ready(s_axil_wready_o),
    .o_data({w_w_strb, w_w_data}), .o_v(w_w_v), .i_yumi(w_req_hs & w_grant_w)
  );

  bsg_axil_fifo_client_fifo #(.width_p(axil_addr_width_p), .els_p(2)) ar_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .i_data(s_axil_araddr_i), .i_v(s_axil_arvalid_i), .o_ready(s_axil_arready_o),
    .o_data(w_ar_addr), .o_v(w_ar_v), .i_yumi(w_req_hs & ~w_grant_w)
  );

  assign w_wr_elig = w_aw_v & w_w_v;
  assign w_rd_elig = w_ar_v;

  // A stalled request keeps its grant; buffer heads cannot move while stalled.
  assign w_grant_w = r_lock_v ? r_lock_w
                              : (w_wr_elig & (~w_rd_elig | ~r_last_grant_w));

  assign v_o      = (w_grant_w ? w_wr_elig : w_rd_elig) & w_trk_ready;
  assign w_o      = w_grant_w;
  assign addr_o   = w_grant_w ? w_aw_addr : w_ar_addr;
  assign data_o   = w_w_data;
  assign wmask_o  = w_w_strb;
  assign w_req_hs = v_o & ready_and_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_last_grant_w <= 1'b0;
      r_lock_v       <= 1'b0;
      r_lock_w       <= 1'b0;
    end else begin
      if (w_req_hs) r_last_grant_w <= w_grant_w;
      r_lock_v <= v_o & ~ready_and_i;
      r_lock_w <= w_grant_w;
    end
  end

  bsg_axil_fifo_client_fifo #(.width_p(1), .els_p(outstanding_els_p)) trk_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .i_data(w_grant_w), .i_v(w_req_hs), .o_ready(w_trk_ready),
    .o_data(w_trk_w), .o_v(w_trk_v), .i_yumi(w_rsp_pop)
  );

  assign ready_and_o     = w_trk_v & (w_trk_w ? s_axil_bready_i : s_axil_rready_i);
  assign s_axil_bvalid_o = w_trk_v & w_trk_w & v_i;
  assign s_axil_rvalid_o = w_trk_v & ~w_trk_w & v_i;
  assign s_axil_rdata_o  = data_i;
  assign s_axil_bresp_o  = 2'b00;
  assign s_axil_rresp_o  = 2'b00;
  assign w_rsp_pop       = v_i & ready_and_o;

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(v_i && !w_trk_v));

endmodule

// File: tb/tb_bsg_axil_fifo_client.sv
// Bench for bsg_axil_fifo_client: request/response scoreboards driven by a vector
// table, plus hand-written sequences for arbitration, stalls, backpressure and reset.

module tb_bsg_axil_fifo_client;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 0;
  logic reset_n = 0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, data_i = '0;
  logic [3:0]  wstrb = '0;
  logic awvalid = 0, wvalid = 0, arvalid = 0;
  logic bready = 1, rready = 1, ready_and = 1, v_i = 0;
  logic awready, wready, arready, bvalid, rvalid, v_o, w_o, ready_and_o;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, addr_o, data_o;
  logic [3:0]  wmask_o;

  int n_checks = 0;
  int n_errors = 0;
  txn_t req_q[$];
  txn_t out_q[$];
  txn_t rsp_q[$];
  bit client_auto = 0;
  bit pop_seen = 0;

  bsg_axil_fifo_client #(
    .axil_data_width_p(32), .axil_addr_width_p(32), .outstanding_els_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(3'b000), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(3'b000), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .addr_o(addr_o), .data_o(data_o), .wmask_o(wmask_o), .w_o(w_o), .v_o(v_o),
    .ready_and_i(ready_and),
    .data_i(data_i), .v_i(v_i), .ready_and_o(ready_and_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Request and response scoreboards, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    txn_t e;
    if (reset_n) begin
      if (v_o && ready_and) begin
        if (req_q.size() == 0) fail("req_unexpected");
        else begin
          e = req_q.pop_front();
          check("req_w", w_o, e.w);
          check("req_addr", addr_o, e.addr);
          if (e.w) begin
            check("req_data", data_o, e.data);
            check("req_wmask", wmask_o, e.strb);
          end
          out_q.push_back(e);
        end
      end
      if (v_i && ready_and_o) pop_seen = 1;
      if (bvalid && rvalid) fail("b_and_r_together");
      if (bvalid && bready) begin
        if (rsp_q.size() == 0) fail("b_unexpected");
        else begin
          e = rsp_q.pop_front();
          check("b_kind_is_write", 1'b1, e.w);
          check("bresp", bresp, 2'b00);
        end
      end
      if (rvalid && rready) begin
        if (rsp_q.size() == 0) fail("r_unexpected");
        else begin
          e = rsp_q.pop_front();
          check("r_kind_is_write", 1'b0, e.w);
          check("rdata", rdata, e.rdata);
          check("rresp", rresp, 2'b00);
        end
      end
    end
  end

  // Client model: answers issued requests in order, one beat at a time.
  always @(posedge clk) begin : client
    txn_t e;
    #1;
    if (!reset_n) v_i = 0;
    else begin
      if (pop_seen) begin
        v_i = 0;
        pop_seen = 0;
      end
      if (!v_i && client_auto && out_q.size() > 0) begin
        e = out_q.pop_front();
        v_i = 1;
        data_i = e.w ? 32'hBAD0_BAD0 : e.rdata;
        rsp_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic delay_cycles(input int d);
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit ok = 0;
    awaddr = a;
    awvalid = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    awvalid = 0;
    if (!ok) fail("aw_timeout");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    wvalid = 0;
    if (!ok) fail("w_timeout");
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 0;
    araddr = a;
    arvalid = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    arvalid = 0;
    if (!ok) fail("ar_timeout");
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_q.size() == 0 && out_q.size() == 0 && rsp_q.size() == 0 && !v_i) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail({name, "_drain_timeout"});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    awvalid = 0;
    wvalid = 0;
    arvalid = 0;
    client_auto = 0;
    req_q.delete();
    out_q.delete();
    rsp_q.delete();
    pop_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs_zero", {awready, wready, arready, v_o, bvalid, rvalid, ready_and_o}, 7'b0);
    @(posedge clk); #1;
    reset_n = 1;
    ready_and = 1;
    bready = 1;
    rready = 1;
    client_auto = 1;
  endtask

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] r);
    txn_t t;
    t.w = w; t.addr = a; t.data = d; t.strb = s; t.rdata = r;
    return t;
  endfunction

  vec_t vecs[6];
  vec_t v;
  logic quiet_acc;

  initial begin
    vecs[0] = '{w:1'b1, addr:32'h10, data:32'hDEADBEEF, strb:4'hF, aw_dly:0, w_dly:2, exp_rdata:32'h0};
    vecs[1] = '{w:1'b0, addr:32'h20, data:32'h0, strb:4'h0, aw_dly:0, w_dly:0, exp_rdata:32'h12345678};
    vecs[2] = '{w:1'b1, addr:32'h24, data:32'hCAFEF00D, strb:4'h3, aw_dly:2, w_dly:0, exp_rdata:32'h0};
    vecs[3] = '{w:1'b1, addr:32'h28, data:32'h0123ABCD, strb:4'h8, aw_dly:0, w_dly:0, exp_rdata:32'h0};
    vecs[4] = '{w:1'b0, addr:32'hFFFFFFFC, data:32'h0, strb:4'h0, aw_dly:0, w_dly:0, exp_rdata:32'hA5A55A5A};
    vecs[5] = '{w:1'b1, addr:32'hFFFFFFFC, data:32'h0, strb:4'h0, aw_dly:1, w_dly:1, exp_rdata:32'h0};

    #1;
    check("pre_edge_outs_zero", {awready, wready, arready, v_o, bvalid, rvalid, ready_and_o}, 7'b0);
    do_reset();

    // Single transactions from the vector table.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      req_q.push_back(mk(v.w, v.addr, v.data, v.strb, v.exp_rdata));
      if (v.w) begin
        fork
          begin delay_cycles(v.aw_dly); send_aw(v.addr); end
          begin delay_cycles(v.w_dly); send_w(v.data, v.strb); end
        join
      end else begin
        send_ar(v.addr);
      end
      drain($sformatf("vec%0d", i));
    end

    // Writes and reads pending together from reset: grants alternate, write first.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_q.push_back(mk(1'b1, 32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF, 32'h0));
      req_q.push_back(mk(1'b0, 32'h200 + 32'(k * 4), 32'h0, 4'h0, 32'hC0DE_0000 + 32'(k)));
    end
    fork
      for (int k = 0; k < 4; k++) send_aw(32'h100 + 32'(k * 4));
      for (int k = 0; k < 4; k++) send_w(32'hA000_0000 + 32'(k), 4'hF);
      for (int k = 0; k < 4; k++) send_ar(32'h200 + 32'(k * 4));
    join
    drain("alternate");

    // Stalled request keeps its grant even when the other kind becomes eligible.
    do_reset();
    ready_and = 0;
    req_q.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 32'h40404040));
    req_q.push_back(mk(1'b1, 32'h44, 32'h44444444, 4'hF, 32'h0));
    send_ar(32'h40);
    fork
      send_aw(32'h44);
      send_w(32'h44444444, 4'hF);
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lock_v_o", v_o, 1'b1);
    check("lock_w_o", w_o, 1'b0);
    check("lock_addr", addr_o, 32'h40);
    @(posedge clk); #1;
    ready_and = 1;
    drain("lock");

    // Request stall fills the AR buffer; then tracking fills and v_o drops.
    do_reset();
    ready_and = 0;
    client_auto = 0;
    for (int k = 0; k < 3; k++)
      req_q.push_back(mk(1'b0, 32'h300 + 32'(k * 4), 32'h0, 4'h0, 32'h5150_0000 + 32'(k)));
    fork
      begin
        send_ar(32'h300);
        send_ar(32'h304);
        send_ar(32'h308);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_arready", arready, 1'b0);
        check("stall_v_o", v_o, 1'b1);
        check("stall_addr", addr_o, 32'h300);
        @(posedge clk); #1;
        ready_and = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("trk_full_v_o", v_o, 1'b0);
        check("trk_full_issued", 32'(req_q.size()), 32'd1);
        check("trk_full_arready", arready, 1'b1);
        @(posedge clk); #1;
        client_auto = 1;
      end
    join
    drain("stall");

    // B backpressure holds the beat and blocks the response pop.
    do_reset();
    bready = 0;
    req_q.push_back(mk(1'b1, 32'h30, 32'h13572468, 4'h5, 32'h0));
    fork
      send_aw(32'h30);
      send_w(32'h13572468, 4'h5);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_bvalid", bvalid, 1'b1);
    check("bp_ready_and_o", ready_and_o, 1'b0);
    check("bp_bresp", bresp, 2'b00);
    check("bp_not_popped", 32'(rsp_q.size()), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_bvalid_held", bvalid, 1'b1);
    @(posedge clk); #1;
    bready = 1;
    drain("bp");

    // Reset with two outstanding reads and a lone buffered AW discards everything.
    do_reset();
    client_auto = 0;
    req_q.push_back(mk(1'b0, 32'h50, 32'h0, 4'h0, 32'h0));
    req_q.push_back(mk(1'b0, 32'h54, 32'h0, 4'h0, 32'h0));
    send_ar(32'h50);
    send_ar(32'h54);
    send_aw(32'h58);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_outstanding", 32'(out_q.size()), 32'd2);
    @(posedge clk); #1;
    do_reset();
    quiet_acc = 0;
    repeat (5) begin
      @(negedge clk);
      quiet_acc = quiet_acc | bvalid | rvalid | v_o | ready_and_o;
    end
    check("post_rst_quiet", quiet_acc, 1'b0);
    @(posedge clk); #1;
    req_q.push_back(mk(1'b1, 32'h64, 32'h66667777, 4'hC, 32'h0));
    req_q.push_back(mk(1'b0, 32'h60, 32'h0, 4'h0, 32'h600D600D));
    fork
      send_aw(32'h64);
      send_w(32'h66667777, 4'hC);
      send_ar(32'h60);
    join
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
